// File: rtl/mem_write_monitor.sv
// Compares CPU data-memory writes against a preloaded table of expected writes and reports pass/fail.
// Define MEM_WRITE_MONITOR_LOG_EN to print pass/fail messages in simulation.
module mem_write_monitor #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_CHK  = 4,
    parameter int IGN_BASE = 80,
    parameter int IGN_SIZE = 4,
    parameter int TIMEOUT  = 1024,
    localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    localparam int CNT_W   = $clog2(NUM_CHK) + 1,
    localparam int CYC_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [15:0]       ign_cnt,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    // One extra bit so the window end cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0] IGN_LO = (ADDR_W+1)'(IGN_BASE);
    localparam logic [ADDR_W:0] IGN_HI = IGN_LO + (ADDR_W+1)'(IGN_SIZE);

    state_t            state_q, state_d;
    logic [1:0]        fail_kind;
    logic [ADDR_W-1:0] tbl_addr [NUM_CHK];
    logic [DATA_W-1:0] tbl_data [NUM_CHK];
    logic [CNT_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  cur_idx;
    logic              addr_hit, data_hit, in_ign, last, timeout;
    logic              complete, data_bad, unexpected;

    assign cur_idx    = match_cnt[IDX_W-1:0];
    assign addr_hit   = (dataadr == tbl_addr[cur_idx]);
    assign data_hit   = (writedata == tbl_data[cur_idx]);
    assign in_ign     = (IGN_SIZE != 0) && ({1'b0, dataadr} >= IGN_LO) && ({1'b0, dataadr} < IGN_HI);
    assign last       = ((match_cnt + CNT_W'(1)) == len_q);
    assign timeout    = (cycle_cnt == CYC_W'(TIMEOUT - 1));
    assign complete   = memwrite && addr_hit && data_hit && last;
    assign data_bad   = memwrite && addr_hit && !data_hit;
    assign unexpected = memwrite && !addr_hit && !in_ign;

    always_comb begin
        len_d = cfg_len;
        if (cfg_len == '0) begin
            len_d = CNT_W'(1);
        end else if (cfg_len > CNT_W'(NUM_CHK)) begin
            len_d = CNT_W'(NUM_CHK);
        end
    end

    // A completing match beats the timeout; the timeout beats any other write outcome.
    always_comb begin
        state_d   = state_q;
        fail_kind = 2'd0;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (complete) begin
                    state_d = PASS;
                end else if (timeout) begin
                    state_d   = FAIL;
                    fail_kind = 2'd3;
                end else if (data_bad) begin
                    state_d   = FAIL;
                    fail_kind = 2'd2;
                end else if (unexpected) begin
                    state_d   = FAIL;
                    fail_kind = 2'd1;
                end
            end
            default: state_d = state_q;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
            len_q     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            cycle_cnt <= '0;
            err_addr  <= '0;
            err_data  <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (cfg_we && (int'(cfg_idx) < NUM_CHK)) begin
                    tbl_addr[cfg_idx] <= cfg_addr;
                    tbl_data[cfg_idx] <= cfg_data;
                end
                if (start && !clear) begin
                    len_q     <= len_d;
                    fail_code <= '0;
                    match_cnt <= '0;
                    ign_cnt   <= '0;
                    cycle_cnt <= '0;
                    err_addr  <= '0;
                    err_data  <= '0;
                end
            end else if (state_q == RUN && !clear) begin
                cycle_cnt <= cycle_cnt + CYC_W'(1);
                if (state_d == FAIL) begin
                    fail_code <= fail_kind;
                    if (fail_kind != 2'd3) begin
                        err_addr <= dataadr;
                        err_data <= writedata;
                    end
                end else if (memwrite && addr_hit && data_hit) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end else if (memwrite && in_ign && (ign_cnt != 16'hFFFF)) begin
                    ign_cnt <= ign_cnt + 16'd1;
                end
            end
            done <= (state_d == PASS) || (state_d == FAIL);
            pass <= (state_d == PASS);
        end
    end

`ifdef MEM_WRITE_MONITOR_LOG_EN
    always @(posedge clk) begin
        if (reset && state_q == RUN && state_d == PASS) begin
            $display("LOG:Simulation succeeded");
        end
        if (reset && state_q == RUN && state_d == FAIL) begin
            $display("LOG:Simulation failed code=%0d adr=%h data=%h", fail_kind,
                     (fail_kind == 2'd3) ? '0 : dataadr, (fail_kind == 2'd3) ? '0 : writedata);
        end
    end
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: expected run results are queued at stimulus time and popped when done rises.
module tb_mem_write_monitor;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_CHK = 4;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 3;
    localparam int CYC_W   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_idx = '0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic [CNT_W-1:0]  cfg_len = '0;
    logic              memwrite = 1'b0;
    logic [ADDR_W-1:0] dataadr = '0;
    logic [DATA_W-1:0] writedata = '0;
    logic              done, pass;
    logic [1:0]        fail_code;
    logic [CNT_W-1:0]  match_cnt;
    logic [15:0]       ign_cnt;
    logic [CYC_W-1:0]  cycle_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             tag;
        logic              done;
        logic              pass;
        logic [1:0]        code;
        logic [CNT_W-1:0]  match;
        logic [15:0]       ign;
        logic [CYC_W-1:0]  cyc;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] edata;
    } exp_t;

    exp_t sb[$];

    mem_write_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHK(NUM_CHK),
        .IGN_BASE(80), .IGN_SIZE(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len(cfg_len), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done), .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt),
        .ign_cnt(ign_cnt), .cycle_cnt(cycle_cnt), .err_addr(err_addr), .err_data(err_data)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_done"}, 64'(done), 64'(0));
        check_output({tag, "_pass"}, 64'(pass), 64'(0));
        check_output({tag, "_code"}, 64'(fail_code), 64'(0));
        check_output({tag, "_match"}, 64'(match_cnt), 64'(0));
        check_output({tag, "_ign"}, 64'(ign_cnt), 64'(0));
        check_output({tag, "_cyc"}, 64'(cycle_cnt), 64'(0));
        check_output({tag, "_eaddr"}, 64'(err_addr), 64'(0));
        check_output({tag, "_edata"}, 64'(err_data), 64'(0));
    endtask

    task automatic expect_result(input string tag, input logic d, input logic p, input logic [1:0] c,
                                 input logic [CNT_W-1:0] m, input logic [15:0] ig, input logic [CYC_W-1:0] cy,
                                 input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed);
        exp_t e;
        e.tag = tag; e.done = d; e.pass = p; e.code = c; e.match = m;
        e.ign = ig; e.cyc = cy; e.eaddr = ea; e.edata = ed;
        sb.push_back(e);
    endtask

    task automatic wait_and_score(input int max_cycles);
        exp_t e;
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (done !== 1'b1) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s_wait observed=done_%b expected=done_1", e.tag, done);
        end
        check_output({e.tag, "_done"}, 64'(done), 64'(e.done));
        check_output({e.tag, "_pass"}, 64'(pass), 64'(e.pass));
        check_output({e.tag, "_code"}, 64'(fail_code), 64'(e.code));
        check_output({e.tag, "_match"}, 64'(match_cnt), 64'(e.match));
        check_output({e.tag, "_ign"}, 64'(ign_cnt), 64'(e.ign));
        check_output({e.tag, "_cyc"}, 64'(cycle_cnt), 64'(e.cyc));
        check_output({e.tag, "_eaddr"}, 64'(err_addr), 64'(e.eaddr));
        check_output({e.tag, "_edata"}, 64'(err_data), 64'(e.edata));
    endtask

    // Stimulus tasks are entered at a falling edge and return at the next falling edge.
    task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] len);
        cfg_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic clear_run();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        #2 check_idle_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        cfg_write(0, 84, 7);
        start_run(1);
        expect_result("t1_pass", 1, 1, 0, 1, 1, 2, 0, 0);
        cpu_write(80, 3);
        cpu_write(84, 7);
        wait_and_score(4);
        clear_run();
        check_output("t1_clear_done", 64'(done), 64'(0));
        check_output("t1_clear_keep_match", 64'(match_cnt), 64'(1));

        start_run(1);
        expect_result("t2_data", 1, 0, 2, 0, 0, 1, 84, 9);
        cpu_write(84, 9);
        wait_and_score(4);
        clear_run();
        check_output("t2_clear_keep_code", 64'(fail_code), 64'(2));

        start_run(1);
        expect_result("t3_addr", 1, 0, 1, 0, 0, 1, 100, 7);
        cpu_write(100, 7);
        wait_and_score(4);
        clear_run();

        start_run(1);
        expect_result("t3b_ign_edge", 1, 0, 2, 0, 1, 2, 84, 5);
        cpu_write(83, 5);
        cpu_write(84, 5);
        wait_and_score(4);
        clear_run();

        cfg_write(0, 0, 1);
        cfg_write(1, 4, 2);
        cfg_write(2, 8, 3);
        start_run(3);
        expect_result("t4_order", 1, 0, 1, 1, 0, 2, 8, 3);
        cpu_write(0, 1);
        cpu_write(8, 3);
        wait_and_score(4);
        clear_run();

        cfg_write(0, 84, 7);
        start_run(1);
        expect_result("t5_timeout", 1, 0, 3, 0, 0, 16, 0, 0);
        repeat (15) @(negedge clk);
        check_output("t5_pre_done", 64'(done), 64'(0));
        check_output("t5_pre_cyc", 64'(cycle_cnt), 64'(15));
        wait_and_score(3);
        clear_run();

        start_run(1);
        expect_result("t5b_last_cycle", 1, 1, 0, 1, 0, 16, 0, 0);
        repeat (15) @(negedge clk);
        cpu_write(84, 7);
        wait_and_score(3);
        clear_run();

        cfg_write(0, 0, 1);
        start_run(3);
        cpu_write(0, 1);
        check_output("t6_pre_match", 64'(match_cnt), 64'(1));
        #2 reset = 1'b0;
        #1 check_idle_zero("t6_mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        start_run(1);
        expect_result("t6_table_zeroed", 1, 1, 0, 1, 0, 1, 0, 0);
        cpu_write(0, 0);
        wait_and_score(4);
        clear_run();

        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        check_output("t7_start_clear_done", 64'(done), 64'(0));
        check_output("t7_start_clear_cyc", 64'(cycle_cnt), 64'(1));
        check_output("t7_start_clear_match", 64'(match_cnt), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Parametrised, synthesizable checker that watches the CPU data-memory write port and decides pass/fail for self-checking programs.
- Holds a table of NUM_CHK expected (address, data) writes, loaded before a run. Writes must match the table in order.
- Writes inside a configurable scratch window are ignored. A cycle timeout bounds each run.
- Sits beside `top` in simulation and FPGA builds; drives a done/pass indication and a failure code instead of ad-hoc bench checks.

Parameters:
- ADDR_W, 32, width of data address.
- DATA_W, 32, width of write data.
- NUM_CHK, 4, number of expected-write table entries (1..16).
- IGN_BASE, 80, first byte address of the ignored scratch window.
- IGN_SIZE, 4, size of the ignored window in bytes; 0 disables the window.
- TIMEOUT, 1024, run-cycle limit; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; honoured only in IDLE.
- clear  in  1  synchronous return to IDLE from any state; table contents are kept.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_idx  in  $clog2(NUM_CHK) (min 1)  table entry index.
- cfg_addr  in  ADDR_W  expected address for the entry.
- cfg_data  in  DATA_W  expected data for the entry.
- cfg_len  in  $clog2(NUM_CHK)+1  number of valid entries, 1..NUM_CHK; latched on start.
- memwrite  in  1  CPU write strobe.
- dataadr  in  ADDR_W  CPU write address.
- writedata  in  DATA_W  CPU write data.
- done  out  1  run finished (PASS or FAIL).
- pass  out  1  run finished successfully.
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout.
- match_cnt  out  $clog2(NUM_CHK)+1  entries matched so far.
- ign_cnt  out  16  ignored writes; saturates at 0xFFFF.
- cycle_cnt  out  $clog2(TIMEOUT+1)  cycles spent in RUN.
- err_addr  out  ADDR_W  address of the failing write; 0 if none.
- err_data  out  DATA_W  data of the failing write; 0 if none.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; table entries 0; len latch 0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - cfg_we writes table[cfg_idx] on the clock edge; cfg_idx >= NUM_CHK is dropped.
  - start=1: latch cfg_len (0 is treated as 1, values above NUM_CHK clamp to NUM_CHK); clear match_cnt, ign_cnt, cycle_cnt, err_*, fail_code; go to RUN.
  - memwrite is ignored.
- RUN: cycle_cnt increments every cycle. When memwrite=1, the write is classified in this priority:
  1. dataadr == table[match_cnt].addr and writedata equal → match_cnt+1. If the new value equals len, go to PASS.
  2. dataadr == table[match_cnt].addr, data differs → FAIL, code 2.
  3. IGN_BASE <= dataadr < IGN_BASE+IGN_SIZE → ign_cnt+1 (saturating); stay in RUN.
  4. Otherwise → FAIL, code 1.
- Only the current table entry is compared; a write matching a later entry counts as unexpected (code 1).
- Timeout: if cycle_cnt == TIMEOUT-1 and no completing match occurs in that cycle → FAIL, code 3. A completing match in the same cycle wins and gives PASS.
- On FAIL from a write: err_addr = dataadr, err_data = writedata. On timeout: err_* stay 0.
- PASS: done=1, pass=1. FAIL: done=1, pass=0. Both hold until clear or reset; start and memwrite are ignored.
- clear in any state → IDLE next cycle. Status outputs keep their values until the next start.
- start and clear asserted together: clear wins.
- Reset asserted mid-run: immediate IDLE with all outputs 0.
- Outputs are registered; decision latency is 1 cycle after the sampling edge.

Optional Feature:
- Macro MEM_WRITE_MONITOR_LOG_EN.
- Defined: on entry to PASS, $display "LOG:Simulation succeeded". On entry to FAIL, $display "LOG:Simulation failed code=<n> adr=<hex> data=<hex>". Each message fires once per run. Simulation only; no effect on logic.
- Undefined: no display statements are compiled; behaviour and ports are identical.

Test Plan:
- Load entry0 = (84, 7), len 1, start; write (80, 3), then (84, 7) → ign_cnt=1, match_cnt=1, done=1, pass=1, fail_code=0.
- Same table; write (84, 9) → FAIL, fail_code=2, err_addr=84, err_data=9.
- Same table; write (100, 7) → FAIL, fail_code=1, err_addr=100.
- Table (0,1), (4,2), (8,3), len 3; writes (0,1), (8,3) → FAIL, code 1 at address 8, match_cnt=1.
- TIMEOUT=16, len 1, no writes → FAIL, code 3 after 16 RUN cycles. Repeat with (84, 7) written in cycle 15 → PASS.
- Drop reset mid-run after one match → all outputs 0 immediately, state IDLE. Assert start and clear together in IDLE → stays IDLE.
